branch_predict_ctrl: RTL and testbench

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl.sv | 167 ++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor control: 2-bit saturating BHT, mispredict redirect and flush sequencing.
// Optional BRANCH_STATS_EN macro adds resolved-branch and mispredict counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | accepting resolves, BHT updates and mispredict detection live
// S_FLUSH | squashing younger stages; resolves are wrong-path and ignored
module branch_predict_ctrl #(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] lookup_pc_in,
    output logic        predict_taken_out,
    input  logic        resolve_valid_in,
    input  logic [31:0] resolve_pc_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic        branch_taken_in,
    input  logic        predicted_taken_in,
    input  logic [31:0] target_in,
    input  logic [31:0] pc_plus4_in,
    output logic        redirect_valid_out,
    output logic [31:0] redirect_pc_out,
`ifdef BRANCH_STATS_EN
    output logic [31:0] branch_count_out,
    output logic [31:0] mispredict_count_out,
`endif
    output logic        flush_out
);

    localparam int         IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [1:0]       bht_q [BHT_ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic             accepted;
    logic             is_branch;
    logic             is_jal;
    logic             actual_taken;
    logic             mispredict;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt;
    logic             unused_pc_bits;

    assign lookup_idx  = lookup_pc_in[IDX_W+1:2];
    assign resolve_idx = resolve_pc_in[IDX_W+1:2];

    // Lookup reads registered state, so a same-cycle update is not visible yet.
    assign predict_taken_out = bht_q[lookup_idx][1];

    assign accepted     = resolve_valid_in && (state_q == S_IDLE);
    assign is_branch    = (opcode_6_to_2_in == OPC_BRANCH);
    assign is_jal       = (opcode_6_to_2_in == OPC_JAL);
    assign actual_taken = is_jal ? 1'b1 : branch_taken_in;
    assign mispredict   = accepted && (is_branch || is_jal) &&
                          (actual_taken != predicted_taken_in);

    assign ctr_cur = bht_q[resolve_idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (branch_taken_in) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (accepted && is_branch) begin
            bht_q[resolve_idx] <= ctr_nxt;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d     = S_IDLE;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (mispredict) redirect_pc_d = actual_taken ? target_in : pc_plus4_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= S_IDLE;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid_out = redirect_valid_q;
    assign redirect_pc_out    = redirect_pc_q;
    assign flush_out          = (state_q == S_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (accepted && (is_branch || is_jal)) branch_count_d = branch_count_q + 32'd1;
        if (mispredict) mispredict_count_d = mispredict_count_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count_out     = branch_count_q;
    assign mispredict_count_out = mispredict_count_q;
`endif

    // Only the index bits of either PC take part in prediction.
    assign unused_pc_bits = ^{lookup_pc_in[31:IDX_W+2], lookup_pc_in[1:0],
                              resolve_pc_in[31:IDX_W+2], resolve_pc_in[1:0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_branch_predict_ctrl;

    localparam int ENTRIES = 16;
    localparam int FLUSH   = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] lookup_pc_in;
    logic        predict_taken_out;
    logic        resolve_valid_in;
    logic [31:0] resolve_pc_in;
    logic [4:0]  opcode_6_to_2_in;
    logic        branch_taken_in;
    logic        predicted_taken_in;
    logic [31:0] target_in;
    logic [31:0] pc_plus4_in;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        flush_out;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_out;
    logic [31:0] mispredict_count_out;
`endif

    branch_predict_ctrl #(.BHT_ENTRIES(ENTRIES), .FLUSH_CYCLES(FLUSH)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .lookup_pc_in       (lookup_pc_in),
        .predict_taken_out  (predict_taken_out),
        .resolve_valid_in   (resolve_valid_in),
        .resolve_pc_in      (resolve_pc_in),
        .opcode_6_to_2_in   (opcode_6_to_2_in),
        .branch_taken_in    (branch_taken_in),
        .predicted_taken_in (predicted_taken_in),
        .target_in          (target_in),
        .pc_plus4_in        (pc_plus4_in),
        .redirect_valid_out (redirect_valid_out),
        .redirect_pc_out    (redirect_pc_out),
`ifdef BRANCH_STATS_EN
        .branch_count_out     (branch_count_out),
        .mispredict_count_out (mispredict_count_out),
`endif
        .flush_out          (flush_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model: counter values as plain integers, flush as cycles remaining.
    int          m_ctr [ENTRIES];
    int          m_flush_left;
    logic        m_rv;
    logic [31:0] m_rpc;
    int          m_branches;
    int          m_misp;
    logic        pred_seen;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  opc;
        logic        taken;
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] pc4;
        logic [31:0] lk;
        logic        e_pred;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
    } vec_t;

    vec_t tab [10];

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] opc, logic tk, logic pr,
                                logic [31:0] tgt, logic [31:0] lk, logic ep, logic erv,
                                logic [31:0] erpc, logic efl);
        vec_t r;
        r.valid = v;   r.pc = pc;    r.opc = opc;   r.taken = tk;  r.pred = pr;
        r.tgt = tgt;   r.pc4 = pc + 32'd4;          r.lk = lk;
        r.e_pred = ep; r.e_rv = erv; r.e_rpc = erpc; r.e_fl = efl;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
        m_flush_left = 0;
        m_rv         = 1'b0;
        m_rpc        = 32'd0;
        m_branches   = 0;
        m_misp       = 0;
    endtask

    task automatic idle_inputs();
        resolve_valid_in   = 1'b0;
        resolve_pc_in      = 32'd0;
        opcode_6_to_2_in   = 5'd0;
        branch_taken_in    = 1'b0;
        predicted_taken_in = 1'b0;
        target_in          = 32'd0;
        pc_plus4_in        = 32'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        lookup_pc_in = 32'h40;
        rst_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    // One clock cycle with the inputs currently driven; checks prediction before the edge
    // and the registered outputs after it.
    task automatic run_cycle();
        int   idx_l, idx_r, act;
        bit   acc, is_br, is_j, mis;
        #1;
        idx_l = (lookup_pc_in >> 2) % ENTRIES;
        pred_seen = predict_taken_out;
        check("predict", {31'd0, predict_taken_out}, (m_ctr[idx_l] >= 2) ? 32'd1 : 32'd0);
        idx_r = (resolve_pc_in >> 2) % ENTRIES;
        acc   = resolve_valid_in && (m_flush_left == 0);
        is_br = (opcode_6_to_2_in == 5'b11000);
        is_j  = (opcode_6_to_2_in == 5'b11011);
        act   = is_j ? 1 : int'(branch_taken_in);
        mis   = acc && (is_br || is_j) && (act != int'(predicted_taken_in));
        @(posedge clk_in);
        if (acc && is_br) begin
            if (branch_taken_in) m_ctr[idx_r] = (m_ctr[idx_r] + 1 > 3) ? 3 : m_ctr[idx_r] + 1;
            else                 m_ctr[idx_r] = (m_ctr[idx_r] - 1 < 0) ? 0 : m_ctr[idx_r] - 1;
        end
        if (acc && (is_br || is_j)) m_branches++;
        m_rv = mis;
        if (mis) begin
            m_misp++;
            m_rpc        = (act != 0) ? target_in : pc_plus4_in;
            m_flush_left = FLUSH;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        #1;
        check("redirect_valid", {31'd0, redirect_valid_out}, {31'd0, m_rv});
        check("redirect_pc", redirect_pc_out, m_rpc);
        check("flush", {31'd0, flush_out}, (m_flush_left > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic [4:0] opc, input logic tk,
                               input logic pr, input logic [31:0] tgt);
        resolve_valid_in   = 1'b1;
        resolve_pc_in      = pc;
        opcode_6_to_2_in   = opc;
        branch_taken_in    = tk;
        predicted_taken_in = pr;
        target_in          = tgt;
        pc_plus4_in        = pc + 32'd4;
    endtask

    initial begin
        // Index 0 is shared by 0x40, 0x80 and 0x100 with 16 entries.
        tab[0] = mk(0, 32'h0,   5'b00000, 0, 0, 32'h0,   32'h40,  0, 0, 32'h0,   0);
        tab[1] = mk(1, 32'h40,  5'b11000, 1, 0, 32'h80,  32'h40,  0, 1, 32'h80,  1);
        tab[2] = mk(0, 32'h0,   5'b00000, 0, 0, 32'h0,   32'h40,  1, 0, 32'h80,  1);
        tab[3] = mk(0, 32'h0,   5'b00000, 0, 0, 32'h0,   32'h40,  1, 0, 32'h80,  0);
        tab[4] = mk(1, 32'h40,  5'b11000, 1, 1, 32'h80,  32'h40,  1, 0, 32'h80,  0);
        tab[5] = mk(0, 32'h0,   5'b00000, 0, 0, 32'h0,   32'h40,  1, 0, 32'h80,  0);
        tab[6] = mk(1, 32'h100, 5'b11011, 0, 0, 32'h200, 32'h100, 1, 1, 32'h200, 1);
        tab[7] = mk(1, 32'h80,  5'b11000, 0, 1, 32'h300, 32'h100, 1, 0, 32'h200, 1);
        tab[8] = mk(1, 32'h80,  5'b11011, 0, 0, 32'h400, 32'h100, 1, 0, 32'h200, 0);
        tab[9] = mk(0, 32'h0,   5'b00000, 0, 0, 32'h0,   32'h100, 1, 0, 32'h200, 0);

        apply_reset();
        check("reset_redirect_valid", {31'd0, redirect_valid_out}, 32'd0);
        check("reset_redirect_pc", redirect_pc_out, 32'd0);
        check("reset_flush", {31'd0, flush_out}, 32'd0);
        check("reset_predict_0x40", {31'd0, predict_taken_out}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (tab[i].valid) set_resolve(tab[i].pc, tab[i].opc, tab[i].taken, tab[i].pred, tab[i].tgt);
            else idle_inputs();
            lookup_pc_in = tab[i].lk;
            run_cycle();
            check($sformatf("tab%0d_pred", i), {31'd0, pred_seen}, {31'd0, tab[i].e_pred});
            check($sformatf("tab%0d_rv", i), {31'd0, redirect_valid_out}, {31'd0, tab[i].e_rv});
            check($sformatf("tab%0d_rpc", i), redirect_pc_out, tab[i].e_rpc);
            check($sformatf("tab%0d_flush", i), {31'd0, flush_out}, {31'd0, tab[i].e_fl});
        end

        // Saturation at 00: four back-to-back correct not-taken branches, then two taken.
        apply_reset();
        lookup_pc_in = 32'h40;
        for (int i = 0; i < 4; i++) begin
            set_resolve(32'h40, 5'b11000, 1'b0, 1'b0, 32'h80);
            run_cycle();
            check("sat_no_redirect", {31'd0, redirect_valid_out}, 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            set_resolve(32'h40, 5'b11000, 1'b1, 1'b0, 32'h80);
            run_cycle();
            idle_inputs();
            repeat (FLUSH) run_cycle();
            run_cycle();
            check(k == 0 ? "sat_after_one_taken" : "sat_after_two_taken",
                  {31'd0, pred_seen}, (k == 0) ? 32'd0 : 32'd1);
        end

        // Reset during the first flush cycle aborts the flush with no residual redirect.
        apply_reset();
        set_resolve(32'h40, 5'b11000, 1'b1, 1'b0, 32'h1234);
        run_cycle();
        check("pre_reset_flush", {31'd0, flush_out}, 32'd1);
        idle_inputs();
        rst_in = 1'b0;
        #1;
        check("async_flush_drop", {31'd0, flush_out}, 32'd0);
        check("async_rv_drop", {31'd0, redirect_valid_out}, 32'd0);
        check("async_rpc_clear", redirect_pc_out, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        repeat (4) begin
            run_cycle();
            check("post_reset_no_redirect", {31'd0, redirect_valid_out}, 32'd0);
        end

        // Randomized traffic with frequent index aliasing.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            int          sel;
            pc  = $urandom;
            pc[1:0] = 2'b00;
            sel = $urandom_range(0, 3);
            idle_inputs();
            if ($urandom_range(0, 9) < 7) begin
                set_resolve(pc, (sel < 2) ? 5'b11000 : (sel == 2) ? 5'b11011 : 5'($urandom),
                            1'($urandom), 1'($urandom), $urandom);
            end
            lookup_pc_in = ($urandom_range(0, 1) == 1) ? pc : {$urandom} & 32'hFFFF_FFFC;
            run_cycle();
        end
`ifdef BRANCH_STATS_EN
        check("stat_branches", branch_count_out, 32'(m_branches));
        check("stat_mispredicts", mispredict_count_out, 32'(m_misp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
